// File: rtl/led_scan_pkg.sv
// Shared types and width helpers for the LED scan multiplexer.
// Holds the per-slot state enum and constant-function width calculators.
package led_scan_pkg;

  typedef enum logic [1:0] {ST_BLANK, ST_ON, ST_OFF} slot_st_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Counter width for a range of n values, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/led_scan_timer.sv
// Scan timebase: slot counter, digit index, frame counter, blink phase, frame start.
// Registered; enable low forces counters to zero but holds the blink phase.
module led_scan_timer
  import led_scan_pkg::*;
#(
  parameter int NUM_DIG      = 6,
  parameter int SCAN_DIV     = 5000,
  parameter int BLINK_FRAMES = 50,
  parameter int CW           = cnt_w(SCAN_DIV),
  parameter int DW           = cnt_w(NUM_DIG)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enable,
  output logic [CW-1:0] cnt,
  output logic [DW-1:0] dig,
  output logic          blink_phase,
  output logic          frame_start
);

  localparam int FW = cnt_w(BLINK_FRAMES);

  logic [FW-1:0] frame_cnt;
  logic          cnt_last;
  logic          dig_last;
  logic          frame_last;

  assign cnt_last   = (cnt == CW'(SCAN_DIV - 1));
  assign dig_last   = (dig == DW'(NUM_DIG - 1));
  assign frame_last = (frame_cnt == FW'(BLINK_FRAMES - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt         <= '0;
      dig         <= '0;
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
      frame_start <= 1'b0;
    end else if (!enable) begin
      cnt         <= '0;
      dig         <= '0;
      frame_cnt   <= '0;
      frame_start <= 1'b0;
    end else begin
      // Delayed one cycle so the top can align it with the output register.
      frame_start <= (cnt == '0) && (dig == '0);
      if (cnt_last) begin
        cnt <= '0;
        if (dig_last) begin
          dig <= '0;
          if (frame_last) begin
            frame_cnt   <= '0;
            blink_phase <= ~blink_phase;
          end else begin
            frame_cnt <= frame_cnt + FW'(1);
          end
        end else begin
          dig <= dig + DW'(1);
        end
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/led_scan_mux.sv
// Round-robin LED digit scanner with blanking gap, PWM brightness, blinking, slot-latched data.
// Outputs registered one cycle after the slot state; LED_SCAN_DP_BLINK_EN makes the dp blink with its digit.
module led_scan_mux
  import led_scan_pkg::*;
#(
  parameter int NUM_DIG      = 6,
  parameter int SEG_W        = 7,
  parameter int SCAN_DIV     = 5000,
  parameter int BLANK_CYC    = 8,
  parameter int DIM_W        = 3,
  parameter int BLINK_FRAMES = 50
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_enable,
  input  logic [NUM_DIG*SEG_W-1:0] i_digit_seg,
  input  logic [NUM_DIG-1:0]       i_dp,
  input  logic [NUM_DIG-1:0]       i_blink_mask,
  input  logic [DIM_W-1:0]         i_bright,
  output logic [SEG_W-1:0]         o_seg,
  output logic                     o_seg_dp,
  output logic [NUM_DIG-1:0]       o_seg_enb,
  output logic                     o_frame_tick
);

  localparam int CW = cnt_w(SCAN_DIV);
  localparam int DW = cnt_w(NUM_DIG);
  localparam int LW = CW + DIM_W + 1;

  logic [CW-1:0]      cnt;
  logic [DW-1:0]      dig;
  logic               blink_phase;
  logic               frame_start;

  logic [LW-1:0]      on_prod;
  logic [LW-1:0]      on_len_calc;
  logic [LW-1:0]      on_len_q;
  logic [LW-1:0]      on_len_cur;
  logic [LW-1:0]      cnt_ext;
  logic               slot_start;

  logic [SEG_W-1:0]   seg_q;
  logic               dp_q;
  logic               vis_q;
  logic [DW-1:0]      dig_q;

  slot_st_e           state_q;
  slot_st_e           state_nxt;

  logic [SEG_W-1:0]   seg_nxt;
  logic               dp_nxt;
  logic [NUM_DIG-1:0] enb_nxt;

  led_scan_timer #(
    .NUM_DIG      (NUM_DIG),
    .SCAN_DIV     (SCAN_DIV),
    .BLINK_FRAMES (BLINK_FRAMES),
    .CW           (CW),
    .DW           (DW)
  ) u_timer (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (i_enable),
    .cnt         (cnt),
    .dig         (dig),
    .blink_phase (blink_phase),
    .frame_start (frame_start)
  );

  assign slot_start  = (cnt == '0);
  assign cnt_ext     = LW'(cnt);
  assign on_prod     = LW'(SCAN_DIV - BLANK_CYC) * (LW'(i_bright) + LW'(1));
  assign on_len_calc = on_prod >> DIM_W;
  // The slot's first cycle classifies against the length being captured right now.
  assign on_len_cur  = slot_start ? on_len_calc : on_len_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg_q    <= '0;
      dp_q     <= 1'b0;
      vis_q    <= 1'b0;
      dig_q    <= '0;
      on_len_q <= '0;
    end else if (slot_start) begin
      seg_q    <= i_digit_seg[int'(dig)*SEG_W +: SEG_W];
      dp_q     <= i_dp[dig];
      vis_q    <= !(blink_phase && i_blink_mask[dig]);
      dig_q    <= dig;
      on_len_q <= on_len_calc;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_BLANK;
    else        state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = ST_BLANK;
    if (i_enable) begin
      if (cnt_ext < LW'(BLANK_CYC))                   state_nxt = ST_BLANK;
      else if (cnt_ext < LW'(BLANK_CYC) + on_len_cur) state_nxt = ST_ON;
      else                                            state_nxt = ST_OFF;
    end
  end

  always_comb begin
    seg_nxt = '0;
    dp_nxt  = 1'b0;
    enb_nxt = '1;
    if (i_enable && state_q == ST_ON) begin
      if (vis_q) begin
        seg_nxt        = seg_q;
        enb_nxt[dig_q] = 1'b0;
      end
`ifdef LED_SCAN_DP_BLINK_EN
      dp_nxt = dp_q && vis_q;
`else
      dp_nxt = dp_q;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      o_seg        <= '0;
      o_seg_dp     <= 1'b0;
      o_seg_enb    <= '1;
      o_frame_tick <= 1'b0;
    end else begin
      o_seg        <= seg_nxt;
      o_seg_dp     <= dp_nxt;
      o_seg_enb    <= enb_nxt;
      o_frame_tick <= i_enable && frame_start;
    end
  end

endmodule

// File: tb/tb_led_scan_mux.sv
// Bench for led_scan_mux: random data against a position-based display model.
// Model maps each enabled cycle to a scan position; outputs appear two cycles later.
module tb_led_scan_mux;

  localparam int ND = 4;
  localparam int SW = 7;
  localparam int SD = 16;
  localparam int BC = 2;
  localparam int DMW = 2;
  localparam int BF = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst_n;
  logic               i_enable;
  logic [ND*SW-1:0]   i_digit_seg;
  logic [ND-1:0]      i_dp;
  logic [ND-1:0]      i_blink_mask;
  logic [DMW-1:0]     i_bright;
  logic [SW-1:0]      o_seg;
  logic               o_seg_dp;
  logic [ND-1:0]      o_seg_enb;
  logic               o_frame_tick;

  led_scan_mux #(
    .NUM_DIG      (ND),
    .SEG_W        (SW),
    .SCAN_DIV     (SD),
    .BLANK_CYC    (BC),
    .DIM_W        (DMW),
    .BLINK_FRAMES (BF)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_enable     (i_enable),
    .i_digit_seg  (i_digit_seg),
    .i_dp         (i_dp),
    .i_blink_mask (i_blink_mask),
    .i_bright     (i_bright),
    .o_seg        (o_seg),
    .o_seg_dp     (o_seg_dp),
    .o_seg_enb    (o_seg_enb),
    .o_frame_tick (o_frame_tick)
  );

  typedef struct packed {
    logic [ND-1:0] enb;
    logic [SW-1:0] seg;
    logic          dp;
    logic          tick;
  } exp_t;

  int          checks = 0;
  int          errors = 0;
  int unsigned r = 0;
  int          phase0 = 0;
  exp_t        prev_e;
  logic [SW-1:0] snap_seg;
  logic          snap_dp;
  logic          snap_mask;
  int            snap_bright;

  function automatic exp_t dark();
    exp_t e;
    e.enb  = '1;
    e.seg  = '0;
    e.dp   = 1'b0;
    e.tick = 1'b0;
    return e;
  endfunction

  function automatic int phase_of(input int unsigned rr);
    return phase0 ^ (((rr / (SD * ND)) / BF) % 2);
  endfunction

  // Expected display for scan position rr, from the slot's captured inputs.
  function automatic exp_t model(input int unsigned rr);
    exp_t e;
    int c, dg, onl;
    logic vis;
    e   = dark();
    c   = rr % SD;
    dg  = (rr / SD) % ND;
    onl = ((SD - BC) * (snap_bright + 1)) / (1 << DMW);
    vis = !(phase_of(rr) != 0 && snap_mask);
    e.tick = (rr % (SD * ND) == 0);
    if (c >= BC && c < BC + onl) begin
      if (vis) begin
        e.enb = ~(4'b0001 << dg);
        e.seg = snap_seg;
      end
`ifdef LED_SCAN_DP_BLINK_EN
      e.dp = snap_dp && vis;
`else
      e.dp = snap_dp;
`endif
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s pos=%0d observed=%0h expected=%0h", tag, r, obs, expv);
    end
  endtask

  task automatic tick();
    logic act;
    exp_t e, x;
    int dg;
    act = rst_n && i_enable;
    e   = dark();
    if (act) begin
      if (r % SD == 0) begin
        dg          = (r / SD) % ND;
        snap_seg    = i_digit_seg[dg*SW +: SW];
        snap_dp     = i_dp[dg];
        snap_mask   = i_blink_mask[dg];
        snap_bright = int'(i_bright);
      end
      e = model(r);
    end
    @(posedge clk);
    x = act ? prev_e : dark();
    if (!rst_n) begin
      r      = 0;
      phase0 = 0;
    end else if (!i_enable) begin
      phase0 = phase_of(r);
      r      = 0;
    end else begin
      r++;
    end
    prev_e = e;
    #1;
    chk("enb",  32'(o_seg_enb),    32'(x.enb));
    chk("seg",  32'(o_seg),        32'(x.seg));
    chk("dp",   32'(o_seg_dp),     32'(x.dp));
    chk("tick", 32'(o_frame_tick), 32'(x.tick));
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Advance (with the scan running) until the frame position equals target.
  task automatic run_to(input int target);
    for (int i = 0; i < SD * ND && (r % (SD * ND)) != target; i++) tick();
  endtask

  initial begin
    prev_e       = dark();
    rst_n        = 1'b0;
    i_enable     = 1'b1;
    i_bright     = 2'd3;
    i_digit_seg  = {7'h79, 7'h6D, 7'h30, 7'h7E};
    i_dp         = 4'($urandom);
    i_blink_mask = 4'b0000;

    // Reset state
    ticks(3);
    chk("rst_enb_all_high", 32'(o_seg_enb), 32'hF);
    chk("rst_seg_zero", 32'(o_seg), 32'h0);
    rst_n = 1'b1;

    // Full brightness round robin
    ticks(2 * SD * ND);

    // Dim codes
    i_bright = 2'd0;
    ticks(SD * ND);
    i_bright = 2'd1;
    ticks(SD * ND);
    for (int i = 0; i < 6; i++) begin
      i_bright = 2'($urandom);
      ticks($urandom_range(10, 40));
    end

    // Blinking from a fresh phase
    rst_n = 1'b0;
    tick();
    rst_n        = 1'b1;
    i_bright     = 2'd3;
    i_blink_mask = 4'b0010;
    ticks(8 * SD * ND);

    // Mid-slot data change on digit 2
    i_blink_mask = 4'b0000;
    run_to(2 * SD + 5);
    i_digit_seg[2*SW +: SW] = 7'($urandom);
    ticks(2 * SD * ND);

    // Enable drop mid-slot
    run_to(SD + 7);
    i_enable = 1'b0;
    ticks(10);
    i_enable = 1'b1;
    ticks(SD * ND + 20);

    // One-edge reset during ON
    run_to(2 * SD + 6);
    rst_n = 1'b0;
    tick();
    chk("midreset_enb", 32'(o_seg_enb), 32'hF);
    rst_n = 1'b1;
    ticks(SD * ND + 20);

    // Random mix including enable drops and blinking
    for (int i = 0; i < 12; i++) begin
      i_digit_seg  = 28'($urandom);
      i_dp         = 4'($urandom);
      i_blink_mask = 4'($urandom);
      i_bright     = 2'($urandom);
      i_enable     = ($urandom_range(0, 4) != 0);
      ticks($urandom_range(20, 150));
    end
    i_enable = 1'b1;
    ticks(SD * ND);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
